alu_md_unit: RTL and testbench

- Parametrised, handshaked successor to the single-cycle datapath ALU.
- Registers every result and keeps the existing 6-bit ALUFunc encoding for arith, logic, shift and compare ops.
- Adds iterative multiply/divide with HI/LO registers, plus MFHI/MFLO.
- Sits in EX stage; the pipeline stalls on in_ready low and flushes via flush.

---
 rtl/alu_md_unit.sv | 191 +++++++++++++++++++
 tb/tb_alu_md_unit.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_md_unit.sv
// Registered, handshaked EX-stage ALU with iterative multiply/divide and HI/LO.
// Optional macro ALU_EXC_EN adds the exc output (signed add/sub overflow, divide by zero).
module alu_md_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [5:0]       ALUFunc,
  input  logic             Signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S
`ifdef ALU_EXC_EN
  ,
  output logic             exc
`endif
);

  localparam logic [5:0] OP_ADD = 6'h00, OP_SUB = 6'h01, OP_MUL = 6'h04, OP_DIV = 6'h05;
  localparam logic [5:0] OP_MFHI = 6'h06, OP_MFLO = 6'h07;
  localparam logic [5:0] OP_AND = 6'h18, OP_OR = 6'h1E, OP_XOR = 6'h16, OP_NOR = 6'h11;
  localparam logic [5:0] OP_PASSA = 6'h1A, OP_SLL = 6'h20, OP_SRL = 6'h21, OP_SRA = 6'h23;
  localparam logic [5:0] OP_EQ = 6'h33, OP_NEQ = 6'h31, OP_LT = 6'h35;
  localparam logic [5:0] OP_LEZ = 6'h3D, OP_LTZ = 6'h3B, OP_GTZ = 6'h3F;

  typedef enum logic [2:0] {IDLE, MUL_RUN, DIV_RUN, FIX, DONE} state_t;

  state_t               r_state, w_next;
  logic [SHW-1:0]       r_count;
  logic [WIDTH-1:0]     r_s, r_hi, r_lo, r_opnd;
  logic [2*WIDTH-1:0]   r_prod;
  logic                 r_negQ, r_negR, r_isDiv, r_divZero;

  logic                 w_accept, w_isMul, w_isDiv, w_lastIter;
  logic [WIDTH-1:0]     w_simple, w_absA, w_absB;
  logic [SHW-1:0]       w_shamt;
  logic [WIDTH:0]       w_mulSum, w_divShift, w_divTrial;
  logic                 w_qBit;
  logic [WIDTH-1:0]     w_divRem, w_quoFix, w_remFix, w_fixHi, w_fixLo;
  logic [2*WIDTH-1:0]   w_prodFix;

  assign w_accept   = in_valid && in_ready;
  assign w_isMul    = (ALUFunc == OP_MUL);
  assign w_isDiv    = (ALUFunc == OP_DIV);
  assign w_lastIter = (r_count == SHW'(WIDTH - 1));
  assign w_shamt    = A[SHW-1:0];
  assign w_absA     = (Signed && A[WIDTH-1]) ? -A : A;
  assign w_absB     = (Signed && B[WIDTH-1]) ? -B : B;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept)                          w_next = w_isMul ? MUL_RUN : (w_isDiv ? DIV_RUN : DONE);
          else if (r_state == DONE && out_ready) w_next = IDLE;
        end
        MUL_RUN, DIV_RUN: if (w_lastIter) w_next = FIX;
        FIX:              w_next = DONE;
        default:          w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = !reset && !flush && ((r_state == IDLE) || (r_state == DONE && out_ready));
    out_valid = (r_state == DONE);
  end

  always_comb begin
    w_simple = '0;
    case (ALUFunc)
      OP_ADD:   w_simple = A + B;
      OP_SUB:   w_simple = A - B;
      OP_AND:   w_simple = A & B;
      OP_OR:    w_simple = A | B;
      OP_XOR:   w_simple = A ^ B;
      OP_NOR:   w_simple = ~(A | B);
      OP_PASSA: w_simple = A;
      OP_SLL:   w_simple = B << w_shamt;
      OP_SRL:   w_simple = B >> w_shamt;
      OP_SRA:   w_simple = $signed(B) >>> w_shamt;
      OP_EQ:    w_simple = WIDTH'(A == B);
      OP_NEQ:   w_simple = WIDTH'(A != B);
      OP_LT:    w_simple = Signed ? WIDTH'($signed(A) < $signed(B)) : WIDTH'(A < B);
      OP_LEZ:   w_simple = WIDTH'(A[WIDTH-1] || (A == '0));
      OP_LTZ:   w_simple = WIDTH'(A[WIDTH-1]);
      OP_GTZ:   w_simple = WIDTH'(!A[WIDTH-1] && (A != '0));
      OP_MFHI:  w_simple = r_hi;
      OP_MFLO:  w_simple = r_lo;
      default:  w_simple = '0;
    endcase
  end

  // r_prod holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  assign w_mulSum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_opnd} : '0);
  assign w_divShift = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1]};
  assign w_divTrial = w_divShift - {1'b0, r_opnd};
  assign w_qBit     = !w_divTrial[WIDTH];
  assign w_divRem   = w_qBit ? w_divTrial[WIDTH-1:0] : w_divShift[WIDTH-1:0];

  assign w_prodFix  = r_negQ ? -r_prod : r_prod;
  assign w_quoFix   = r_divZero ? '1 : (r_negQ ? -r_prod[WIDTH-1:0] : r_prod[WIDTH-1:0]);
  assign w_remFix   = r_negR ? -r_prod[2*WIDTH-1:WIDTH] : r_prod[2*WIDTH-1:WIDTH];
  assign w_fixHi    = r_isDiv ? w_remFix : w_prodFix[2*WIDTH-1:WIDTH];
  assign w_fixLo    = r_isDiv ? w_quoFix : w_prodFix[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_opnd    <= '0;
      r_prod    <= '0;
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
      r_isDiv   <= 1'b0;
      r_divZero <= 1'b0;
      r_count   <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else begin
      r_count <= '0;
      case (r_state)
        MUL_RUN: begin
          r_prod  <= {w_mulSum, r_prod[WIDTH-1:1]};
          r_count <= r_count + SHW'(1);
        end
        DIV_RUN: begin
          r_prod  <= {w_divRem, r_prod[WIDTH-2:0], w_qBit};
          r_count <= r_count + SHW'(1);
        end
        FIX: begin
          r_hi <= w_fixHi;
          r_lo <= w_fixLo;
          r_s  <= w_fixLo;
        end
        default: ;
      endcase
      if (w_accept) begin
        if (w_isMul || w_isDiv) begin
          r_opnd    <= w_isMul ? w_absA : w_absB;
          r_prod    <= {{WIDTH{1'b0}}, (w_isMul ? w_absB : w_absA)};
          r_negQ    <= Signed && (A[WIDTH-1] ^ B[WIDTH-1]);
          r_negR    <= Signed && A[WIDTH-1];
          r_isDiv   <= w_isDiv;
          r_divZero <= (B == '0);
        end else begin
          r_s <= w_simple;
        end
      end
    end
  end

  assign S = r_s;

`ifdef ALU_EXC_EN
  logic r_exc;
  logic w_ovf;

  always_comb begin
    w_ovf = 1'b0;
    if (Signed && ALUFunc == OP_ADD)
      w_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (w_simple[WIDTH-1] != A[WIDTH-1]);
    else if (Signed && ALUFunc == OP_SUB)
      w_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (w_simple[WIDTH-1] != A[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (reset || flush)                      r_exc <= 1'b0;
    else if (r_state == FIX)                 r_exc <= r_isDiv && r_divZero;
    else if (w_accept && !w_isMul && !w_isDiv) r_exc <= w_ovf;
  end

  assign exc = r_exc;
`endif

endmodule

// File: tb/tb_alu_md_unit.sv
// Bench for alu_md_unit: directed literal cases plus randomized traffic against an arithmetic model.
// Honours ALU_EXC_EN when the bench and design are built with it.
module tb_alu_md_unit;

  localparam int W = 32;
  localparam logic [5:0] ADD = 6'h00, SUB = 6'h01, MUL = 6'h04, DIV = 6'h05;
  localparam logic [5:0] MFHI = 6'h06, MFLO = 6'h07, SRA = 6'h23, LT = 6'h35;

  logic          clk = 0;
  logic          reset = 1, flush = 0, in_valid = 0, out_ready = 1, Signed = 0;
  logic [W-1:0]  A = '0, B = '0;
  logic [5:0]    ALUFunc = '0;
  logic          in_ready, out_valid;
  logic [W-1:0]  S;

  logic          v16 = 0, sg16 = 0, fl16 = 0, or16 = 1;
  logic [15:0]   a16 = '0, b16 = '0;
  logic [5:0]    f16 = '0;
  logic          ir16, ov16;
  logic [15:0]   s16;

`ifdef ALU_EXC_EN
  logic exc, exc16;
`endif

  int vecCount = 0;
  int missCount = 0;
  bit chkEn = 0;

  always #5 clk = ~clk;

  alu_md_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUFunc(ALUFunc), .Signed(Signed), .out_valid(out_valid),
    .out_ready(out_ready), .S(S)
`ifdef ALU_EXC_EN
    , .exc(exc)
`endif
  );

  alu_md_unit #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .flush(fl16), .in_valid(v16), .in_ready(ir16),
    .A(a16), .B(b16), .ALUFunc(f16), .Signed(sg16), .out_valid(ov16),
    .out_ready(or16), .S(s16)
`ifdef ALU_EXC_EN
    , .exc(exc16)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic, written from the opcode definitions rather than the datapath
  function automatic logic [31:0] refSimple(input logic [5:0] f, input logic [31:0] a, b,
                                            input logic s, input logic [31:0] hi, lo);
    int sa, sb, sh;
    sa = a; sb = b; sh = int'(a[4:0]);
    case (f)
      6'h00: return a + b;
      6'h01: return a - b;
      6'h18: return a & b;
      6'h1E: return a | b;
      6'h16: return a ^ b;
      6'h11: return ~(a | b);
      6'h1A: return a;
      6'h20: return b << sh;
      6'h21: return b >> sh;
      6'h23: return sb >>> sh;
      6'h33: return {31'b0, a == b};
      6'h31: return {31'b0, a != b};
      6'h35: return s ? {31'b0, sa < sb} : {31'b0, a < b};
      6'h3D: return {31'b0, sa <= 0};
      6'h3B: return {31'b0, sa < 0};
      6'h3F: return {31'b0, sa > 0};
      6'h06: return hi;
      6'h07: return lo;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic refOvf(input logic [5:0] f, input logic [31:0] a, b, input logic s);
    longint la, lb, r;
    la = longint'($signed(a)); lb = longint'($signed(b));
    if (!s || (f != 6'h00 && f != 6'h01)) return 1'b0;
    r = (f == 6'h00) ? la + lb : la - lb;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  task automatic refMulDiv(input logic [5:0] f, input logic [31:0] a, b, input logic s,
                           output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ia = a; ib = b;
    if (f == 6'h04) begin
      p = s ? 64'(sa * sb) : ({32'b0, a} * {32'b0, b});
      hi = p[63:32]; lo = p[31:0];
    end else if (b == 0) begin
      lo = 32'hFFFFFFFF; hi = a;
    end else if (s) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
        lo = 32'h80000000; hi = 32'h0;
      end else begin
        lo = ia / ib; hi = ia % ib;
      end
    end else begin
      lo = a / b; hi = a % b;
    end
  endtask

  // Model state: 0 idle, 1 busy with iterative op, 2 holding a result
  int          mState = 0;
  int          mCount = 0;
  bit          mValid = 0, mExc = 0, mPendExc = 0;
  logic [31:0] mS = '0, mHi = '0, mLo = '0, mPendHi = '0, mPendLo = '0;

  always @(posedge clk) begin
    bit rdy;
    rdy = !reset && !flush && ((mState == 0) || (mState == 2 && out_ready));
    if (reset) begin
      mState = 0; mValid = 0; mS = '0; mHi = '0; mLo = '0; mExc = 0;
    end else if (flush) begin
      mState = 0; mValid = 0; mExc = 0;
    end else begin
      if (mState == 2 && out_ready) begin
        mState = 0; mValid = 0;
      end
      if (mState == 1) begin
        mCount--;
        if (mCount == 0) begin
          mHi = mPendHi; mLo = mPendLo; mS = mPendLo; mExc = mPendExc;
          mValid = 1; mState = 2;
        end
      end
      if (rdy && in_valid) begin
        if (ALUFunc == MUL || ALUFunc == DIV) begin
          refMulDiv(ALUFunc, A, B, Signed, mPendHi, mPendLo);
          mPendExc = (ALUFunc == DIV) && (B == 0);
          mCount = W + 1; mState = 1; mValid = 0;
        end else begin
          mS = refSimple(ALUFunc, A, B, Signed, mHi, mLo);
          mExc = refOvf(ALUFunc, A, B, Signed);
          mValid = 1; mState = 2;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit expRdy;
    if (chkEn) begin
      expRdy = !reset && !flush && ((mState == 0) || (mState == 2 && out_ready));
      checkOutput("in_ready", 32'(in_ready), 32'(expRdy));
      checkOutput("out_valid", 32'(out_valid), 32'(mValid));
      if (mValid) checkOutput("S", S, mS);
`ifdef ALU_EXC_EN
      if (mValid) checkOutput("exc", 32'(exc), 32'(mExc));
`endif
    end
  end

  logic [31:0] res;
  int          busy;
  bit          lastExc;

  task automatic applyStimulus(input logic [5:0] f, input logic [31:0] a, b, input logic s,
                               output logic [31:0] r, output int waitCycles);
    int guard;
    ALUFunc = f; A = a; B = b; Signed = s; in_valid = 1; out_ready = 1;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      missCount++;
      $display("[TB] FAIL accept_timeout: in_ready stayed 0, required 1");
    end
    @(posedge clk); #2;
    in_valid = 0;
    waitCycles = 0;
    @(negedge clk);
    while (!out_valid && waitCycles < 200) begin
      waitCycles++;
      @(negedge clk);
    end
    if (waitCycles >= 200) begin
      missCount++;
      $display("[TB] FAIL result_timeout: out_valid stayed 0, required 1");
    end
    r = S;
`ifdef ALU_EXC_EN
    lastExc = exc;
`else
    lastExc = 0;
`endif
    @(posedge clk); #2;
  endtask

  logic [5:0] opTable [22] = '{6'h00, 6'h01, 6'h18, 6'h1E, 6'h16, 6'h11, 6'h1A, 6'h20,
                              6'h21, 6'h23, 6'h33, 6'h31, 6'h35, 6'h3D, 6'h3B, 6'h3F,
                              6'h04, 6'h05, 6'h06, 6'h07, 6'h3E, 6'h02};

  function automatic logic [31:0] pickOperand();
    logic [31:0] specials [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    @(posedge clk); #2;
    chkEn = 1;
    @(negedge clk);
    checkOutput("reset_S", S, 32'h0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'h0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk); #2;
    reset = 0;

    // Back-to-back ADD then SUB
    ALUFunc = ADD; A = 7; B = 5; Signed = 0; in_valid = 1;
    @(posedge clk); #2;
    ALUFunc = SUB; A = 5; B = 7;
    @(negedge clk);
    checkOutput("add_S", S, 32'd12);
    checkOutput("add_valid", 32'(out_valid), 32'h1);
    checkOutput("b2b_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #2;
    in_valid = 0;
    @(negedge clk);
    checkOutput("sub_S", S, 32'hFFFFFFFE);
    @(posedge clk); #2;

    applyStimulus(MUL, 32'hFFFFFFFD, 32'd7, 1, res, busy);
    checkOutput("smul_S", res, 32'hFFFFFFEB);
    checkOutput("mul_latency", 32'(busy), 32'd33);
    applyStimulus(MFHI, 0, 0, 0, res, busy);
    checkOutput("smul_HI", res, 32'hFFFFFFFF);
    applyStimulus(MUL, 32'hFFFFFFFD, 32'd7, 0, res, busy);
    checkOutput("umul_S", res, 32'hFFFFFFEB);
    applyStimulus(MFHI, 0, 0, 0, res, busy);
    checkOutput("umul_HI", res, 32'h00000006);

    applyStimulus(DIV, 32'hFFFFFFF9, 32'd2, 1, res, busy);
    checkOutput("sdiv_LO", res, 32'hFFFFFFFD);
    applyStimulus(MFHI, 0, 0, 0, res, busy);
    checkOutput("sdiv_HI", res, 32'hFFFFFFFF);

    applyStimulus(DIV, 32'h12345678, 32'h0, 0, res, busy);
    checkOutput("div0_LO", res, 32'hFFFFFFFF);
    checkOutput("div0_latency", 32'(busy), 32'd33);
`ifdef ALU_EXC_EN
    checkOutput("div0_exc", 32'(lastExc), 32'h1);
`endif
    applyStimulus(MFHI, 0, 0, 0, res, busy);
    checkOutput("div0_HI", res, 32'h12345678);

    applyStimulus(DIV, 32'h80000000, 32'hFFFFFFFF, 1, res, busy);
    checkOutput("minneg1_LO", res, 32'h80000000);
    applyStimulus(MFHI, 0, 0, 0, res, busy);
    checkOutput("minneg1_HI", res, 32'h0);

    applyStimulus(SRA, 32'd4, 32'h80000000, 0, res, busy);
    checkOutput("sra", res, 32'hF8000000);
    checkOutput("simple_latency", 32'(busy), 32'd0);
    applyStimulus(LT, 32'hFFFFFFFF, 32'd1, 1, res, busy);
    checkOutput("lt_signed", res, 32'h1);
    applyStimulus(LT, 32'hFFFFFFFF, 32'd1, 0, res, busy);
    checkOutput("lt_unsigned", res, 32'h0);
    applyStimulus(ADD, 32'h7FFFFFFF, 32'd1, 1, res, busy);
    checkOutput("add_ovf_S", res, 32'h80000000);
`ifdef ALU_EXC_EN
    checkOutput("add_ovf_exc", 32'(lastExc), 32'h1);
`endif

    // Backpressure: result held while out_ready is low
    out_ready = 0; ALUFunc = ADD; A = 3; B = 4; Signed = 0; in_valid = 1;
    @(posedge clk); #2;
    ALUFunc = SUB;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("hold_S", S, 32'd7);
      checkOutput("hold_valid", 32'(out_valid), 32'h1);
      checkOutput("hold_ready", 32'(in_ready), 32'h0);
    end
    @(posedge clk); #2;
    out_ready = 1;
    @(posedge clk); #2;
    in_valid = 0;
    @(negedge clk);
    checkOutput("release_S", S, 32'hFFFFFFFF);
    @(posedge clk); #2;

    // Flush an in-flight DIV; HI/LO keep the previous division
    applyStimulus(DIV, 32'd100, 32'd7, 0, res, busy);
    checkOutput("div_100_7", res, 32'd14);
    ALUFunc = DIV; A = 32'd1000; B = 32'd3; in_valid = 1;
    @(posedge clk); #2;
    in_valid = 0;
    repeat (9) @(posedge clk);
    #2 flush = 1;
    @(posedge clk); #2;
    flush = 0;
    @(negedge clk);
    checkOutput("flush_valid", 32'(out_valid), 32'h0);
    checkOutput("flush_ready", 32'(in_ready), 32'h1);
    applyStimulus(MFLO, 0, 0, 0, res, busy);
    checkOutput("flush_LO", res, 32'd14);
    applyStimulus(MFHI, 0, 0, 0, res, busy);
    checkOutput("flush_HI", res, 32'd2);

    // Reset in the middle of a MUL clears HI/LO
    applyStimulus(MUL, 32'd5, 32'd6, 0, res, busy);
    ALUFunc = MUL; A = 32'hFFFF; B = 32'hFFFF; in_valid = 1;
    @(posedge clk); #2;
    in_valid = 0;
    repeat (5) @(posedge clk);
    #2 reset = 1;
    @(posedge clk); #2;
    reset = 0;
    @(negedge clk);
    checkOutput("rst_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_ready", 32'(in_ready), 32'h1);
    applyStimulus(MFHI, 0, 0, 0, res, busy);
    checkOutput("rst_HI", res, 32'h0);
    applyStimulus(MFLO, 0, 0, 0, res, busy);
    checkOutput("rst_LO", res, 32'h0);

    // 16-bit instance: latency scales with WIDTH
    f16 = MUL; a16 = 16'hFFFD; b16 = 16'd7; sg16 = 1; v16 = 1;
    @(negedge clk);
    checkOutput("w16_ready", 32'(ir16), 32'h1);
    @(posedge clk); #2;
    v16 = 0;
    busy = 0;
    @(negedge clk);
    while (!ov16 && busy < 100) begin
      busy++;
      @(negedge clk);
    end
    checkOutput("w16_latency", 32'(busy), 32'd17);
    checkOutput("w16_S", 32'(s16), 32'h0000FFEB);
    @(posedge clk); #2;

    // Randomized traffic, checked every cycle against the model
    for (int c = 0; c < 3000; c++) begin
      ALUFunc   = opTable[$urandom_range(0, 21)];
      A         = pickOperand();
      B         = pickOperand();
      Signed    = ($urandom_range(0, 1) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 80) == 0);
      reset     = ($urandom_range(0, 600) == 0);
      @(posedge clk); #2;
    end
    in_valid = 0; flush = 0; reset = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
